// File: rtl/kyber_decrypt.sv
// rtl/kyber_decrypt.sv - Baby Kyber decryption: w = v - s.u over Z17[x]/(x^4+1), one serial MAC
module kyber_decrypt #(
   parameter int COEF_W = 32,
   parameter int Q      = 17,
   parameter int N_MAC  = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic signed [1:0][3:0][COEF_W-1:0]    secretkey,
   input  logic signed [1:0][3:0][COEF_W-1:0]    u_in,
   input  logic signed [3:0][COEF_W-1:0]         v_in,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [3:0]                            message,
   output logic [3:0][COEF_W-1:0]                w_out,
   output logic                                  busy
);

   typedef enum logic [1:0] {IDLE, MAC, REDUCE, DONE} state_t;

   localparam logic signed [COEF_W-1:0] QS = COEF_W'(Q);
   // A coefficient decodes to 1 when it lies nearer Q/2 than 0 (5..12 for Q=17)
   localparam logic signed [COEF_W-1:0] LO = COEF_W'((Q + 3) / 4);
   localparam logic signed [COEF_W-1:0] HI = COEF_W'(Q - (Q + 3) / 4);
   localparam logic [4:0]               K_LAST = 5'(N_MAC - 1);

   state_t                     state;
   logic [4:0]                 k;
   logic signed [COEF_W-1:0]   s_r [2][4];
   logic signed [COEF_W-1:0]   u_r [2][4];
   logic signed [COEF_W-1:0]   v_r [4];
   logic signed [COEF_W-1:0]   acc [4];

   logic                       p;
   logic [1:0]                 i;
   logic [1:0]                 j;
   logic [2:0]                 sum3;
   logic [1:0]                 idx;
   logic                       wrap;
   logic signed [COEF_W-1:0]   prod;
   logic signed [COEF_W-1:0]   d    [4];
   logic signed [COEF_W-1:0]   r    [4];
   logic signed [COEF_W-1:0]   w_next [4];
   logic [3:0]                 msg_next;

   always_comb begin
      p    = k[4];
      i    = k[3:2];
      j    = k[1:0];
      sum3 = {1'b0, i} + {1'b0, j};
      idx  = sum3[1:0];
      // x^4 = -1: products landing past degree 3 are subtracted
      wrap = sum3[2];
      prod = s_r[p][i] * u_r[p][j];
      msg_next = '0;
      for (int n = 0; n < 4; n++) begin
         d[n]      = v_r[n] - acc[n];
         r[n]      = d[n] % QS;
         w_next[n] = (r[n] < 0) ? r[n] + QS : r[n];
         msg_next[n] = (w_next[n] >= LO) && (w_next[n] <= HI);
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid && in_ready) begin
         for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 4; b++) begin
               s_r[a][b] <= $signed(secretkey[a][b]);
               u_r[a][b] <= $signed(u_in[a][b]);
            end
         end
         for (int b = 0; b < 4; b++) v_r[b] <= $signed(v_in[b]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         k         <= '0;
         for (int n = 0; n < 4; n++) acc[n] <= '0;
         message   <= '0;
         w_out     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  k        <= '0;
                  for (int n = 0; n < 4; n++) acc[n] <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc[idx] <= wrap ? acc[idx] - prod : acc[idx] + prod;
               k        <= k + 5'd1;
               if (k == K_LAST) state <= REDUCE;
            end
            REDUCE: begin
               for (int n = 0; n < 4; n++) w_out[n] <= w_next[n];
               message <= msg_next;
               busy    <= 1'b0;
               state   <= DONE;
            end
            DONE: begin
               // result registers settle one cycle before out_valid is raised
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
